// File: rtl/snake_pkg.sv
// Shared snake game definitions: coordinates, directions, FSM states and wall limits.
package snake_pkg;

    typedef logic [10:0] coord_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
    } pt_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DEAD = 2'b10,
        WON  = 2'b11
    } state_t;

    localparam logic [1:0] DIR_RIGHT = 2'b00;
    localparam logic [1:0] DIR_LEFT  = 2'b01;
    localparam logic [1:0] DIR_UP    = 2'b10;
    localparam logic [1:0] DIR_DOWN  = 2'b11;

    localparam coord_t WALL_X_MIN = 11'd212;
    localparam coord_t WALL_X_MAX = 11'd468;
    localparam coord_t WALL_Y_MIN = 11'd112;
    localparam coord_t WALL_Y_MAX = 11'd368;

    // Opposite directions differ only in the LSB of the encoding.
    function automatic logic [1:0] dir_reverse(input logic [1:0] d);
        return d ^ 2'b01;
    endfunction

    function automatic logic outside_walls(input pt_t p);
        return (p.x < WALL_X_MIN) || (p.x > WALL_X_MAX) ||
               (p.y < WALL_Y_MIN) || (p.y > WALL_Y_MAX);
    endfunction

endpackage

// File: rtl/snake_seg_match.sv
// Compares one point against segments FIRST..MAX_LEN-1, counting only indices below len_i.
module snake_seg_match
    import snake_pkg::*;
#(
    parameter int MAX_LEN = 40,
    parameter int FIRST   = 0
) (
    input  pt_t                  pt_i,
    input  pt_t [MAX_LEN-1:0]    seg_i,
    input  logic [7:0]           len_i,
    output logic                 hit_o
);

    always_comb begin
        hit_o = 1'b0;
        for (int i = FIRST; i < MAX_LEN; i++) begin
            if ((i < int'(len_i)) && (seg_i[i] == pt_i)) begin
                hit_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/snake_body_ctrl.sv
// Snake body/game-state controller; SNAKE_SELF_COLLISION_EN enables the self-hit check.
// state | meaning: IDLE shown, static | RUN moving on ticks | DEAD lost | WON reached MAX_LEN
module snake_body_ctrl
    import snake_pkg::*;
#(
    parameter int MAX_LEN   = 40,
    parameter int START_LEN = 3,
    parameter int START_X   = 340,
    parameter int START_Y   = 240
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        iMoveTick,
    input  logic        iDirValid,
    input  logic [1:0]  iDir,
    input  logic [10:0] iFoodLocationX,
    input  logic [10:0] iFoodLocationY,
    input  logic [10:0] iPixelRow,
    input  logic [10:0] iPixelCol,
    output logic [7:0]  oSnakeLength,
    output logic        oRandEn,
    output logic        oCtrlOff,
    output logic [1:0]  oSnakePixel
);

    state_t               state_q;
    logic [1:0]           dir_q;
    logic [1:0]           pend_q;
    logic                 eval_q;
    logic [7:0]           len_q;
    logic                 rand_q;
    logic                 off_q;
    logic [1:0]           pix_q;
    pt_t [MAX_LEN-1:0]    seg_q;

    pt_t  head_d;
    pt_t  pix_pt;
    pt_t  food_pt;
    logic pix_hit;
    logic self_hit;

    assign pix_pt  = '{x: iPixelCol, y: iPixelRow};
    assign food_pt = '{x: iFoodLocationX, y: iFoodLocationY};

    always_comb begin
        head_d = seg_q[0];
        case (pend_q)
            DIR_RIGHT: head_d.x = seg_q[0].x + 11'd1;
            DIR_LEFT:  head_d.x = seg_q[0].x - 11'd1;
            DIR_UP:    head_d.y = seg_q[0].y - 11'd1;
            default:   head_d.y = seg_q[0].y + 11'd1;
        endcase
    end

    snake_seg_match #(.MAX_LEN(MAX_LEN), .FIRST(0)) u_pix_match (
        .pt_i  (pix_pt),
        .seg_i (seg_q),
        .len_i (len_q),
        .hit_o (pix_hit)
    );

`ifdef SNAKE_SELF_COLLISION_EN
    snake_seg_match #(.MAX_LEN(MAX_LEN), .FIRST(1)) u_self_match (
        .pt_i  (seg_q[0]),
        .seg_i (seg_q),
        .len_i (len_q),
        .hit_o (self_hit)
    );
`else
    assign self_hit = 1'b0;
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            dir_q   <= DIR_RIGHT;
            pend_q  <= DIR_RIGHT;
            eval_q  <= 1'b0;
            len_q   <= 8'(START_LEN);
            rand_q  <= 1'b0;
            off_q   <= 1'b0;
            pix_q   <= 2'b00;
            for (int i = 0; i < MAX_LEN; i++) begin
                if (i < START_LEN) begin
                    seg_q[i].x <= coord_t'(START_X - i);
                    seg_q[i].y <= coord_t'(START_Y);
                end else begin
                    seg_q[i] <= '0;
                end
            end
        end else begin
            rand_q <= 1'b0;
            pix_q  <= {1'b0, pix_hit};
            // Pending direction is checked against the direction of the last move.
            if (iDirValid && (state_q == IDLE || state_q == RUN) &&
                (iDir != dir_reverse(dir_q))) begin
                pend_q <= iDir;
            end
            case (state_q)
                IDLE: begin
                    if (iDirValid) state_q <= RUN;
                end
                RUN: begin
                    if (eval_q) begin
                        eval_q <= 1'b0;
                        if (outside_walls(seg_q[0]) || self_hit) begin
                            state_q <= DEAD;
                            off_q   <= 1'b1;
                        end else if (seg_q[0] == food_pt) begin
                            rand_q <= 1'b1;
                            if (len_q < 8'(MAX_LEN)) len_q <= len_q + 8'd1;
                            if (len_q + 8'd1 == 8'(MAX_LEN)) begin
                                state_q <= WON;
                                off_q   <= 1'b1;
                            end
                        end
                    end else if (iMoveTick) begin
                        for (int i = 1; i < MAX_LEN; i++) begin
                            seg_q[i] <= seg_q[i-1];
                        end
                        seg_q[0] <= head_d;
                        dir_q    <= pend_q;
                        eval_q   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign oSnakeLength = len_q;
    assign oRandEn      = rand_q;
    assign oCtrlOff     = off_q;
    assign oSnakePixel  = pix_q;

endmodule

// File: tb/tb_snake_body_ctrl.sv
// Directed bench for snake_body_ctrl; head position is observed through the pixel output.
module tb_snake_body_ctrl;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        iMoveTick;
    logic        iDirValid;
    logic [1:0]  iDir;
    logic [10:0] iFoodLocationX;
    logic [10:0] iFoodLocationY;
    logic [10:0] iPixelRow;
    logic [10:0] iPixelCol;
    logic [7:0]  oSnakeLength;
    logic        oRandEn;
    logic        oCtrlOff;
    logic [1:0]  oSnakePixel;

    int nvec = 0;
    int nmis = 0;

    snake_body_ctrl dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .iMoveTick      (iMoveTick),
        .iDirValid      (iDirValid),
        .iDir           (iDir),
        .iFoodLocationX (iFoodLocationX),
        .iFoodLocationY (iFoodLocationY),
        .iPixelRow      (iPixelRow),
        .iPixelCol      (iPixelCol),
        .oSnakeLength   (oSnakeLength),
        .oRandEn        (oRandEn),
        .oCtrlOff       (oCtrlOff),
        .oSnakePixel    (oSnakePixel)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nmis++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic do_tick();
        iMoveTick = 1'b1;
        @(negedge Clock);
        iMoveTick = 1'b0;
    endtask

    task automatic move();
        do_tick();
        cyc(4);
    endtask

    task automatic req_dir(input logic [1:0] d);
        iDirValid = 1'b1;
        iDir      = d;
        @(negedge Clock);
        iDirValid = 1'b0;
    endtask

    task automatic set_food(input int x, input int y);
        iFoodLocationX = 11'(x);
        iFoodLocationY = 11'(y);
    endtask

    task automatic probe(input string tag, input int x, input int y, input int exp);
        iPixelCol = 11'(x);
        iPixelRow = 11'(y);
        @(negedge Clock);
        chk(tag, 32'(oSnakePixel), 32'(exp));
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
    endtask

    initial begin
        Reset = 1'b1;
        iMoveTick = 1'b0;
        iDirValid = 1'b0;
        iDir = 2'b00;
        iPixelRow = 11'd0;
        iPixelCol = 11'd0;
        set_food(0, 0);
        cyc(2);
        Reset = 1'b0;

        chk("rst_len", 32'(oSnakeLength), 3);
        chk("rst_rand", 32'(oRandEn), 0);
        chk("rst_off", 32'(oCtrlOff), 0);
        chk("rst_pix", 32'(oSnakePixel), 0);
        probe("rst_head", 340, 240, 1);
        probe("rst_tail", 338, 240, 1);
        probe("rst_past_tail", 337, 240, 0);
        probe("rst_off_row", 340, 241, 0);

        move();
        probe("idle_no_move", 341, 240, 0);

        req_dir(2'b00);
        do_tick();
        chk("mv1_rand_n1", 32'(oRandEn), 0);
        cyc(1);
        chk("mv1_rand_n2", 32'(oRandEn), 0);
        chk("mv1_len", 32'(oSnakeLength), 3);
        chk("mv1_off", 32'(oCtrlOff), 0);
        cyc(3);
        probe("mv1_head", 341, 240, 1);
        probe("mv1_old_tail", 338, 240, 0);

        set_food(342, 240);
        do_tick();
        chk("eat_rand_n1", 32'(oRandEn), 0);
        cyc(1);
        chk("eat_rand_n2", 32'(oRandEn), 1);
        chk("eat_len", 32'(oSnakeLength), 4);
        cyc(1);
        chk("eat_rand_n3", 32'(oRandEn), 0);
        set_food(0, 0);
        cyc(2);

        req_dir(2'b01);
        move();
        probe("rev_head", 343, 240, 1);
        probe("rev_body", 341, 240, 1);
        probe("rev_beyond", 339, 240, 0);

        set_food(344, 240);
        move();
        set_food(0, 0);
        chk("grow5_len", 32'(oSnakeLength), 5);

        req_dir(2'b11);
        move();
        req_dir(2'b01);
        move();
        req_dir(2'b10);
        move();
`ifdef SNAKE_SELF_COLLISION_EN
        chk("self_hit_off", 32'(oCtrlOff), 1);
`else
        chk("self_hit_off", 32'(oCtrlOff), 0);
`endif
        probe("self_head", 343, 240, 1);

        do_reset();
        chk("rst2_len", 32'(oSnakeLength), 3);
        chk("rst2_off", 32'(oCtrlOff), 0);
        chk("rst2_rand", 32'(oRandEn), 0);
        probe("rst2_tail", 338, 240, 1);
        probe("rst2_no_341", 341, 240, 0);
        probe("rst2_no_343_241", 343, 241, 0);

        req_dir(2'b00);
        for (int k = 0; k < 128; k++) move();
        chk("wall_468_off", 32'(oCtrlOff), 0);
        probe("wall_468_head", 468, 240, 1);
        do_tick();
        chk("wall_off_n1", 32'(oCtrlOff), 0);
        cyc(1);
        chk("wall_off_n2", 32'(oCtrlOff), 1);
        chk("wall_rand", 32'(oRandEn), 0);
        cyc(3);
        move();
        probe("dead_no_move", 470, 240, 0);
        probe("dead_head_kept", 469, 240, 1);
        chk("dead_len", 32'(oSnakeLength), 3);

        do_reset();
        req_dir(2'b00);
        for (int k = 0; k < 36; k++) begin
            set_food(341 + k, 240);
            move();
        end
        chk("len39", 32'(oSnakeLength), 39);
        chk("len39_off", 32'(oCtrlOff), 0);
        set_food(377, 240);
        do_tick();
        chk("win_off_n1", 32'(oCtrlOff), 0);
        cyc(1);
        chk("win_rand", 32'(oRandEn), 1);
        chk("win_len", 32'(oSnakeLength), 40);
        chk("win_off", 32'(oCtrlOff), 1);
        cyc(1);
        chk("win_rand_n3", 32'(oRandEn), 0);
        set_food(0, 0);
        cyc(2);
        move();
        chk("won_len_hold", 32'(oSnakeLength), 40);
        probe("won_head", 377, 240, 1);
        probe("won_no_move", 378, 240, 0);
        probe("won_tail", 338, 240, 1);
        probe("won_past_tail", 337, 240, 0);

        do_reset();
        req_dir(2'b00);
        set_food(341, 240);
        do_tick();
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        chk("rst_eval_rand", 32'(oRandEn), 0);
        chk("rst_eval_len", 32'(oSnakeLength), 3);
        chk("rst_eval_off", 32'(oCtrlOff), 0);
        set_food(0, 0);
        probe("rst_eval_seg", 341, 240, 0);

        req_dir(2'b00);
        iDirValid = 1'b1;
        iDir      = 2'b11;
        iMoveTick = 1'b1;
        @(negedge Clock);
        iDirValid = 1'b0;
        iMoveTick = 1'b0;
        cyc(4);
        probe("coinc_cur_move", 341, 240, 1);
        probe("coinc_not_down", 340, 241, 0);
        move();
        probe("coinc_next_down", 341, 241, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
